// File: rtl/fifo_single_clock_reg_v3_if.sv
// Bundle between a producer/consumer (master) and the FIFO (slave).
// Requests and write data flow in; read data, occupancy and status flow out.
interface fifo_single_clock_reg_v3_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 4
);
  logic              w_req;
  logic [DATA_W-1:0] w_data;
  logic              r_req;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [DEPTH_W-1:0] cnt;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              w_fail;
  logic              r_fail;
  logic              clr_sticky;
  logic              ovf_sticky;
  logic              unf_sticky;

  modport master (
    output w_req, w_data, r_req, clr_sticky,
    input  r_data, r_valid, cnt, empty, full,
    input  almost_empty, almost_full,
    input  w_fail, r_fail, ovf_sticky, unf_sticky
  );

  modport slave (
    input  w_req, w_data, r_req, clr_sticky,
    output r_data, r_valid, cnt, empty, full,
    output almost_empty, almost_full,
    output w_fail, r_fail, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/fifo_single_clock_reg_v3.sv
// Single-clock register FIFO, any depth, FWFT or registered read output.
// Ports: clk, nrst (async low), bus (slave: req/data in, data/status out).
module fifo_single_clock_reg_v3 #(
  parameter string FWFT_MODE = "TRUE",
  parameter int    DEPTH     = 8,
  parameter int    DEPTH_W   = $clog2(DEPTH+1),
  parameter int    DATA_W    = 32,
  parameter int    AF_LEVEL  = DEPTH-1,
  parameter int    AE_LEVEL  = 1
) (
  input logic                    clk,
  input logic                    nrst,
  fifo_single_clock_reg_v3_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit FWFT  = (FWFT_MODE == "TRUE");
  localparam logic [DEPTH_W-1:0] FULL_C = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] AF_C   = DEPTH_W'(AF_LEVEL);
  localparam logic [DEPTH_W-1:0] AE_C   = DEPTH_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0]   LAST_C = PTR_W'(DEPTH-1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be >= 2");
  end
  if (DEPTH_W < $clog2(DEPTH+1)) begin : g_bad_dw
    $error("DEPTH_W too narrow for 0..DEPTH");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
    $error("AE_LEVEL out of range 0..DEPTH-1");
  end
  if (FWFT_MODE != "TRUE" && FWFT_MODE != "FALSE") begin : g_bad_mode
    $error("FWFT_MODE must be TRUE or FALSE");
  end

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]   w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0]   r_ptr_q, r_ptr_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               full, empty, wa, ra;
  logic               w_fail, r_fail;

  always_comb begin
    full    = (cnt_q == FULL_C);
    empty   = (cnt_q == '0);
    w_fail  = bus.w_req && full;
    r_fail  = bus.r_req && empty;
    wa      = bus.w_req && !full;
    ra      = bus.r_req && !empty;
    cnt_d   = cnt_q + DEPTH_W'(wa) - DEPTH_W'(ra);
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    // explicit wrap so non-power-of-2 depths never index past DEPTH-1
    if (wa) w_ptr_d = (w_ptr_q == LAST_C) ? '0 : w_ptr_q + PTR_W'(1);
    if (ra) r_ptr_d = (r_ptr_q == LAST_C) ? '0 : r_ptr_q + PTR_W'(1);
    // set dominates clear
    ovf_d   = w_fail || (ovf_q && !bus.clr_sticky);
    unf_d   = r_fail || (unf_q && !bus.clr_sticky);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa) mem[w_ptr_q] <= bus.w_data;
  end

  assign bus.cnt          = cnt_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.w_fail       = w_fail;
  assign bus.r_fail       = r_fail;
  assign bus.ovf_sticky   = ovf_q;
  assign bus.unf_sticky   = unf_q;

  if (FWFT) begin : g_fwft
    assign bus.r_data  = empty ? '0 : mem[r_ptr_q];
    assign bus.r_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;

    always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = ra;
      if (ra) r_data_d = mem[r_ptr_q];
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
  end
endmodule

// File: tb/tb_fifo_single_clock_reg_v3.sv
// Directed bench: DEPTH=5 FWFT instance and DEPTH=8 registered instance.
// Immediate assertions at each check; one summary line at the end.
module tb_fifo_single_clock_reg_v3;
  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_single_clock_reg_v3_if #(.DATA_W(32), .DEPTH_W(3)) ia ();
  fifo_single_clock_reg_v3_if #(.DATA_W(32), .DEPTH_W(4)) ib ();

  fifo_single_clock_reg_v3 #(
    .FWFT_MODE("TRUE"), .DEPTH(5), .DATA_W(32)
  ) u_a (
    .clk(clk), .nrst(nrst), .bus(ia)
  );

  fifo_single_clock_reg_v3 #(
    .FWFT_MODE("FALSE"), .DEPTH(8), .DATA_W(32),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_b (
    .clk(clk), .nrst(nrst), .bus(ib)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0;
    ia.w_req = 0; ia.r_req = 0; ia.w_data = 0; ia.clr_sticky = 0;
    ib.w_req = 0; ib.r_req = 0; ib.w_data = 0; ib.clr_sticky = 0;
    repeat (2) tick();
    chk("a_rst_cnt", ia.cnt, 0);
    chk("a_rst_empty", ia.empty, 1);
    chk("a_rst_full", ia.full, 0);
    chk("a_rst_ae", ia.almost_empty, 1);
    chk("a_rst_af", ia.almost_full, 0);
    chk("a_rst_rv", ia.r_valid, 0);
    chk("a_rst_rd", ia.r_data, 0);
    chk("b_rst_cnt", ib.cnt, 0);
    chk("b_rst_rv", ib.r_valid, 0);
    chk("b_rst_rd", ib.r_data, 0);
    chk("b_rst_ovf", ib.ovf_sticky, 0);
    nrst = 1'b1;

    // A: fill 0x10..0x14
    for (int i = 0; i < 5; i++) begin
      ia.w_req = 1; ia.w_data = 32'h10 + i;
      tick();
      chk("a_fill_cnt", ia.cnt, i + 1);
      chk("a_fill_head", ia.r_data, 32'h10);
      chk("a_fill_rv", ia.r_valid, 1);
    end
    chk("a_full", ia.full, 1);
    chk("a_af", ia.almost_full, 1);
    ia.w_data = 32'hFF;
    #1;
    chk("a_wfail", ia.w_fail, 1);
    tick();
    ia.w_req = 0;
    chk("a_full_cnt", ia.cnt, 5);
    chk("a_ovf", ia.ovf_sticky, 1);
    ia.clr_sticky = 1;
    tick();
    ia.clr_sticky = 0;
    chk("a_ovf_clr", ia.ovf_sticky, 0);

    // A: drain
    for (int i = 0; i < 5; i++) begin
      ia.r_req = 1;
      #1;
      chk("a_drain_rd", ia.r_data, 32'h10 + i);
      tick();
    end
    ia.r_req = 0;
    chk("a_empty", ia.empty, 1);
    chk("a_empty_rd", ia.r_data, 0);
    chk("a_empty_rv", ia.r_valid, 0);
    ia.r_req = 1;
    #1;
    chk("a_rfail", ia.r_fail, 1);
    tick();
    ia.r_req = 0;
    chk("a_unf", ia.unf_sticky, 1);
    chk("a_unf_cnt", ia.cnt, 0);

    // A: steady state at cnt=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      ia.w_req = 1; ia.w_data = 32'h20 + i;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      ia.w_req = 1; ia.r_req = 1; ia.w_data = 32'h22 + i;
      #1;
      chk("a_pair_rd", ia.r_data, 32'h20 + i);
      chk("a_pair_wf", ia.w_fail, 0);
      chk("a_pair_rf", ia.r_fail, 0);
      tick();
      chk("a_pair_cnt", ia.cnt, 2);
    end
    ia.w_req = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("a_tail_rd", ia.r_data, 32'h2C + i);
      tick();
    end
    ia.r_req = 0;
    chk("a_tail_empty", ia.empty, 1);

    // B: fill with threshold tracking
    for (int i = 0; i < 8; i++) begin
      ib.w_req = 1; ib.w_data = 32'h30 + i;
      tick();
      chk("b_fill_cnt", ib.cnt, i + 1);
      chk("b_fill_ae", ib.almost_empty, (i + 1) <= 2);
      chk("b_fill_af", ib.almost_full, (i + 1) >= 6);
      chk("b_fill_rv", ib.r_valid, 0);
    end
    chk("b_full", ib.full, 1);
    ib.r_req = 1; ib.w_data = 32'hEE;
    #1;
    chk("b_wfail", ib.w_fail, 1);
    chk("b_rfail0", ib.r_fail, 0);
    tick();
    ib.w_req = 0; ib.r_req = 0;
    chk("b_rw_cnt", ib.cnt, 7);
    chk("b_rw_rv", ib.r_valid, 1);
    chk("b_rw_rd", ib.r_data, 32'h30);
    chk("b_rw_ovf", ib.ovf_sticky, 1);
    tick();
    chk("b_rv_drop", ib.r_valid, 0);
    chk("b_rd_hold", ib.r_data, 32'h30);
    ib.w_req = 1; ib.w_data = 32'h38;
    tick();
    chk("b_refill", ib.cnt, 8);
    ib.clr_sticky = 1;
    tick();
    chk("b_set_wins", ib.ovf_sticky, 1);
    ib.w_req = 0;
    tick();
    ib.clr_sticky = 0;
    chk("b_clr", ib.ovf_sticky, 0);

    // B: drain with r_req held
    for (int i = 0; i < 8; i++) begin
      ib.r_req = 1;
      tick();
      chk("b_drain_rd", ib.r_data, 32'h31 + i);
      chk("b_drain_rv", ib.r_valid, 1);
    end
    ib.r_req = 0;
    tick();
    chk("b_drain_rv0", ib.r_valid, 0);
    chk("b_drain_empty", ib.empty, 1);

    // B: simultaneous on empty
    ib.w_req = 1; ib.r_req = 1; ib.w_data = 32'hAB;
    #1;
    chk("b_rfail", ib.r_fail, 1);
    tick();
    ib.w_req = 0;
    chk("b_ab_cnt", ib.cnt, 1);
    chk("b_ab_rv", ib.r_valid, 0);
    chk("b_unf", ib.unf_sticky, 1);
    tick();
    ib.r_req = 0;
    chk("b_ab_rd", ib.r_data, 32'hAB);
    chk("b_ab_rv1", ib.r_valid, 1);
    tick();
    chk("b_ab_rv0", ib.r_valid, 0);

    // B: async reset mid-burst at cnt=4
    for (int i = 0; i < 4; i++) begin
      ib.w_req = 1; ib.w_data = 32'h40 + i;
      tick();
    end
    chk("b_pre_rst_cnt", ib.cnt, 4);
    ib.r_req = 1;
    tick();
    chk("b_pre_rst_rv", ib.r_valid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("b_arst_cnt", ib.cnt, 0);
    chk("b_arst_empty", ib.empty, 1);
    chk("b_arst_rv", ib.r_valid, 0);
    chk("b_arst_rd", ib.r_data, 0);
    chk("b_arst_unf", ib.unf_sticky, 0);
    chk("b_arst_ae", ib.almost_empty, 1);
    chk("b_arst_af", ib.almost_full, 0);
    ib.r_req = 0; ib.w_req = 1; ib.w_data = 32'h55;
    #1 nrst = 1'b1;
    tick();
    ib.w_req = 0;
    chk("b_post_rst_cnt", ib.cnt, 1);
    ib.r_req = 1;
    tick();
    ib.r_req = 0;
    chk("b_post_rst_rd", ib.r_data, 32'h55);
    chk("b_post_rst_rv", ib.r_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
